// File: rtl/frame_mem_arbiter_if.sv
// Requester, memory and flow-control signals shared by the frame memory arbiter
// and its environment. The arbiter takes the slave view.
interface frame_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 24
);
  // display fetch (read requester)
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_grant;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  // pixel-update engine (write requester)
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_grant;

  // pixel FIFO flow control
  logic              fifo_afull;

  // single-port frame memory
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, fifo_afull, mem_rdata,
    output rd_grant, rd_valid, rd_data, wr_grant, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, fifo_afull, mem_rdata,
    input  rd_grant, rd_valid, rd_data, wr_grant, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/frame_mem_arbiter.sv
// Arbitrates the single-port frame memory between display reads (default winner)
// and updater writes, which get bounded bursts on starvation or FIFO almost-full.
module frame_mem_arbiter #(
  parameter int unsigned ADDR_W   = 13,
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned WR_BURST = 4,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  frame_mem_arbiter_if.slave bus
);

  localparam logic [7:0] WAIT_LIM  = 8'(MAX_WAIT - 1);
  localparam logic [3:0] BURST_LIM = 4'(WR_BURST);

  typedef enum logic {
    S_RD_PRI,
    S_WR_BURST
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_wait_cnt;
  logic [3:0]          r_burst_cnt;
  logic [3:0]          w_burst_inc;
  logic [RD_LAT-1:0]   r_rd_pipe;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;

  logic                w_force;
  logic                w_rd_grant;
  logic                w_wr_grant;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_wdata;

  // A pending write is forced through when the display can stall or it has waited too long.
  assign w_force     = bus.fifo_afull || (r_wait_cnt == WAIT_LIM);
  assign w_burst_inc = (r_burst_cnt == 4'hF) ? r_burst_cnt : r_burst_cnt + 4'd1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RD_PRI;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RD_PRI: begin
        if (w_wr_grant && w_force) begin
          w_state_nxt = S_WR_BURST;
        end
      end
      S_WR_BURST: begin
        if (!bus.wr_req) begin
          w_state_nxt = S_RD_PRI;
        end else if (!bus.fifo_afull && (w_burst_inc >= BURST_LIM)) begin
          w_state_nxt = S_RD_PRI;
        end
      end
      default: w_state_nxt = S_RD_PRI;
    endcase
  end

  // Output logic: grants are gated while reset is asserted so nothing reaches memory
  always_comb begin
    w_rd_grant = 1'b0;
    w_wr_grant = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_RD_PRI: begin
          if (bus.rd_req && !w_force) begin
            w_rd_grant = 1'b1;
          end else if (bus.wr_req) begin
            w_wr_grant = 1'b1;
          end
        end
        S_WR_BURST: begin
          w_wr_grant = bus.wr_req;
        end
        default: begin
          w_rd_grant = 1'b0;
          w_wr_grant = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    if (w_rd_grant) begin
      w_mem_addr = bus.rd_addr;
    end else if (w_wr_grant) begin
      w_mem_addr  = bus.wr_addr;
      w_mem_wdata = bus.wr_data;
    end
  end

  assign bus.rd_grant  = w_rd_grant;
  assign bus.wr_grant  = w_wr_grant;
  assign bus.mem_we    = w_wr_grant;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.rd_valid  = r_rd_pipe[RD_LAT-1];
  assign bus.rd_data   = bus.mem_rdata;

  // Idle cycles keep the last address/data on the memory pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (!bus.wr_req || w_wr_grant) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != WAIT_LIM) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_burst_cnt <= '0;
    end else if (r_state == S_RD_PRI) begin
      if (w_state_nxt == S_WR_BURST) begin
        r_burst_cnt <= 4'd1;
      end
    end else if (w_wr_grant) begin
      r_burst_cnt <= w_burst_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pipe <= '0;
    end else begin
      r_rd_pipe[0] <= w_rd_grant;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_rd_pipe[i] <= r_rd_pipe[i-1];
      end
    end
  end

endmodule
